note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
Downstream consumer of the tempo divider's one-cycle beat pulse. On each beat it fetches the next 32-bit note word from the 64x32 song RAM and presents it to the note renderer over a valid/ready handshake. It tracks song position, pause, end-of-song and beat overrun. It sits between the tempo divider, the song RAM and the renderer/game-logic stage.

Parameters:
ADDR_W, 6, song RAM address width.
DATA_W, 32, note word width.
SONG_LEN, 64, number of note slots played; must be between 1 and 2**ADDR_W.
END_WORD, 32'hFFFF_FFFF, sentinel word that terminates a song early.

Ports:
clk  in  1  system clock (50 MHz).
resetn  in  1  synchronous, active-low reset.
beat_tick  in  1  one-cycle beat pulse from the tempo divider.
start  in  1  level or pulse; begins or restarts playback.
pause  in  1  level; while high, beats are not consumed.
mem_addr  out  ADDR_W  song RAM read address.
mem_rdata  in  DATA_W  song RAM read data, valid 1 cycle after mem_addr.
note_valid  out  1  note_data is valid.
note_ready  in  1  renderer accepts the note.
note_data  out  DATA_W  current note word.
note_idx  out  ADDR_W  index of the presented note.
playing  out  1  high in every state except IDLE and DONE.
done  out  1  high in DONE.
overrun  out  1  sticky; a beat was lost.

Behaviour:
- Reset (resetn=0 at posedge clk) takes priority over all other inputs, including mid-song: state=IDLE, idx=0, pending=0. All outputs are 0.
- States are IDLE, WAIT_BEAT, FETCH, LATCH, PRESENT, DONE.
- mem_addr is idx, registered; it is never X.
- IDLE: on start go to WAIT_BEAT, with idx=0 and overrun cleared.
- WAIT_BEAT: if (beat_tick|pending) and !pause, go to FETCH and clear pending. If pause=1, a tick sets pending; pending is held, not dropped.
- FETCH: one cycle; the RAM read is in flight.
- LATCH: if mem_rdata==END_WORD, go to DONE and present nothing. Otherwise register note_data=mem_rdata and note_idx=idx, set note_valid=1, and go to PRESENT.
- PRESENT: note_valid stays high and note_data/note_idx stay stable until note_valid&note_ready.
  - On the handshake, note_valid=0 in the next cycle.
  - If idx==SONG_LEN-1, go to DONE; otherwise idx+1 and go to WAIT_BEAT.
  - Pause does not abort a presented note.
- Beat during FETCH, LATCH or PRESENT: if pending=0, set pending; if pending=1, set overrun (sticky until start or reset).
  - A tick on the same cycle as the handshake follows the same rule.
  - Minimum beat-to-valid latency is 3 cycles (tick at cycle T, valid at T+3). With note_ready tied high, one note is presented per beat.
- DONE: done=1 and playing=0. start re-enters WAIT_BEAT with idx=0, pending=0 and overrun=0.
- start outside IDLE/DONE is ignored.
- idx arithmetic is modulo 2**ADDR_W and never exceeds SONG_LEN-1.

Optional Feature:
NOTE_SEQ_LOOP_EN
- Defined: reaching the end (last index handshake, or END_WORD in LATCH) wraps idx to 0 and goes to WAIT_BEAT. DONE is unreachable and done stays 0. pending and overrun are preserved across the wrap. An END_WORD at idx 0 still goes to DONE, to avoid an infinite empty loop.
- Undefined: the behaviour described above.

Decomposition:
- Shared package note_pkg holds:
  - the state enum;
  - ADDR_W/DATA_W defaults and END_WORD;
  - note-word field offsets: [31:28] lane, [27:24] type, [23:0] payload. These offsets are used by the renderer, not by this block.
- One natural sub-module: beat_pending, the 1-deep tick accumulator with overrun detect. Everything else stays in a single FSM module.

Test Plan:
- Reset then start; RAM word k=k+1; note_ready=1; ticks every 10 cycles → note_valid 3 cycles after each tick; note_data 1,2,3… with note_idx 0,1,2…; done=1 after idx 63 with SONG_LEN=64.
- RAM[5]=32'hFFFF_FFFF → notes 0–4 presented; done asserts 3 cycles after the 6th tick; no valid for idx 5.
- Hold note_ready=0 across 2 extra ticks → first tick sets pending (no overrun); second sets overrun=1; note_data stays stable; after ready, the next note starts immediately from pending.
- pause=1, tick arrives → no fetch; pause=0 → FETCH next cycle; note presented 3 cycles later.
- resetn=0 while PRESENT at idx 20 → next cycle all outputs 0 and state IDLE; start restarts at idx 0.
- With NOTE_SEQ_LOOP_EN and SONG_LEN=4 → note_idx sequence 0,1,2,3,0,1…; done never asserts.

Source files
------------

// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer and note renderer.
package note_pkg;

    localparam int unsigned NOTE_ADDR_W = 6;
    localparam int unsigned NOTE_DATA_W = 32;
    localparam logic [31:0] NOTE_END_WORD = 32'hFFFF_FFFF;

    // Note-word layout: [31:28] lane, [27:24] type, [23:0] payload.
    localparam int unsigned LANE_LSB  = 28;
    localparam int unsigned TYPE_LSB  = 24;
    localparam int unsigned FIELD_W   = 4;
    localparam int unsigned PAYLOAD_W = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BEAT,
        S_FETCH,
        S_LATCH,
        S_PRESENT,
        S_DONE
    } seq_state_e;

    function automatic logic [31:0] make_note(input logic [FIELD_W-1:0]   lane,
                                              input logic [FIELD_W-1:0]   ntype,
                                              input logic [PAYLOAD_W-1:0] payload);
        logic [31:0] w;
        w = '0;
        w[LANE_LSB +: FIELD_W] = lane;
        w[TYPE_LSB +: FIELD_W] = ntype;
        w[0 +: PAYLOAD_W]      = payload;
        return w;
    endfunction

endpackage

// File: rtl/note_sequencer_beat_pending.sv
// One-deep beat accumulator: remembers one unconsumed beat, flags any further beat as overrun.
module note_sequencer_beat_pending (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic consume,
    input  logic arm,
    output logic pending,
    output logic overrun
);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (consume) begin
            pending <= 1'b0;
        end else if (arm) begin
            if (pending) begin
                overrun <= 1'b1;
            end else begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Beat-driven note fetcher: reads the song RAM on each beat and presents notes over valid/ready.
// Optional build macro NOTE_SEQ_LOOP_EN makes the song wrap to index 0 instead of ending.
module note_sequencer
    import note_pkg::*;
#(
    parameter int unsigned       ADDR_W   = NOTE_ADDR_W,
    parameter int unsigned       DATA_W   = NOTE_DATA_W,
    parameter int unsigned       SONG_LEN = 64,
    parameter logic [DATA_W-1:0] END_WORD = DATA_W'(NOTE_END_WORD)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              beat_tick,
    input  logic              start,
    input  logic              pause,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [DATA_W-1:0] note_data,
    output logic [ADDR_W-1:0] note_idx,
    output logic              playing,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

    seq_state_e        state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [DATA_W-1:0] data_n;
    logic [ADDR_W-1:0] nidx_n;
    logic              valid_n;
    logic              pending;
    logic              consume_c, arm_c, clear_c, hs_c;

    assign mem_addr = idx;

    note_sequencer_beat_pending u_beat_pending (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear_c),
        .consume (consume_c),
        .arm     (arm_c),
        .pending (pending),
        .overrun (overrun)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        data_n    = note_data;
        nidx_n    = note_idx;
        valid_n   = note_valid;
        consume_c = 1'b0;
        arm_c     = 1'b0;
        clear_c   = 1'b0;
        hs_c      = note_valid & note_ready;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_WAIT_BEAT;
                    idx_n   = '0;
                    clear_c = 1'b1;
                end
            end
            S_WAIT_BEAT: begin
                if (pause) begin
                    arm_c = beat_tick;
                end else if (beat_tick || pending) begin
                    state_n   = S_FETCH;
                    consume_c = 1'b1;
                end
            end
            S_FETCH: begin
                arm_c   = beat_tick;
                state_n = S_LATCH;
            end
            S_LATCH: begin
                arm_c = beat_tick;
                if (mem_rdata == END_WORD) begin
`ifdef NOTE_SEQ_LOOP_EN
                    // An end marker at slot 0 would loop forever on nothing, so stop there.
                    if (idx != '0) begin
                        idx_n   = '0;
                        state_n = S_WAIT_BEAT;
                    end else begin
                        state_n = S_DONE;
                    end
`else
                    state_n = S_DONE;
`endif
                end else begin
                    data_n  = mem_rdata;
                    nidx_n  = idx;
                    valid_n = 1'b1;
                    state_n = S_PRESENT;
                end
            end
            S_PRESENT: begin
                arm_c = beat_tick;
                if (hs_c) begin
                    valid_n = 1'b0;
                    if (idx == LAST_IDX) begin
`ifdef NOTE_SEQ_LOOP_EN
                        idx_n   = '0;
                        state_n = S_WAIT_BEAT;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        idx_n   = idx + ADDR_W'(1);
                        state_n = S_WAIT_BEAT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            idx        <= '0;
            note_valid <= 1'b0;
            note_data  <= '0;
            note_idx   <= '0;
            playing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            note_valid <= valid_n;
            note_data  <= data_n;
            note_idx   <= nidx_n;
            playing    <= (state_n != S_IDLE) && (state_n != S_DONE);
            done       <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer; build with NOTE_SEQ_LOOP_EN to exercise the looping variant.
module tb_note_sequencer;
    import note_pkg::*;

    localparam int unsigned ADDR_W = NOTE_ADDR_W;
    localparam int unsigned DATA_W = NOTE_DATA_W;
`ifdef NOTE_SEQ_LOOP_EN
    localparam int unsigned SONG_LEN = 4;
`else
    localparam int unsigned SONG_LEN = 64;
`endif

    logic              clk = 1'b0;
    logic              resetn, beat_tick, start, pause, note_ready;
    logic [ADDR_W-1:0] mem_addr, note_idx;
    logic [DATA_W-1:0] mem_rdata, note_data;
    logic              note_valid, playing, done, overrun;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;

    note_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SONG_LEN(SONG_LEN)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .beat_tick  (beat_tick),
        .start      (start),
        .pause      (pause),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_data  (note_data),
        .note_idx   (note_idx),
        .playing    (playing),
        .done       (done),
        .overrun    (overrun)
    );

    always #10 clk = ~clk;

    // Synchronous-read song RAM model.
    always @(posedge clk) mem_rdata <= ram[mem_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_note(input int k);
        exp_t e;
        e.idx  = ADDR_W'(k);
        e.data = ram[k];
        sb.push_back(e);
    endtask

    // Waits (bounded) for note_valid; a pending beat_tick is dropped after one cycle.
    task automatic wait_valid(input int limit, output int lat);
        lat = 0;
        while (note_valid !== 1'b1 && lat < limit) begin
            @(negedge clk);
            beat_tick = 1'b0;
            lat++;
        end
        if (note_valid !== 1'b1) lat = -1;
    endtask

    task automatic pulse_tick();
        beat_tick = 1'b1;
        cyc(1);
        beat_tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        check("rst_valid", note_valid, 0);
        check("rst_playing", playing, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_note_idx", note_idx, 0);
        check("rst_note_data", note_data, 0);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic play_note(input int k, input int exp_lat);
        int lat;
        expect_note(k);
        beat_tick = 1'b1;
        wait_valid(8, lat);
        check("beat_to_valid", lat, exp_lat);
        cyc(7);
    endtask

    // Monitor: pops the scoreboard on every accepted note.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (note_valid === 1'b1 && note_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_note: got idx %0d data %0h expected none", note_idx, note_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("note_idx", note_idx, e.idx);
                    check("note_data", note_data, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic saw_valid;
        resetn     = 1'b0;
        beat_tick  = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        note_ready = 1'b1;
        for (int k = 0; k < 2**ADDR_W; k++) ram[k] = DATA_W'(k + 1);
        cyc(1);

`ifdef NOTE_SEQ_LOOP_EN
        // Looping: indices wrap 0..3 and done never rises.
        do_reset();
        do_start();
        for (int k = 0; k < 10; k++) begin
            play_note(k % SONG_LEN, 3);
            check("loop_done_low", done, 0);
        end
        check("loop_playing", playing, 1);

        // End marker mid-song wraps to slot 0 without presenting anything.
        ram[2] = NOTE_END_WORD;
        do_reset();
        do_start();
        play_note(0, 3);
        play_note(1, 3);
        beat_tick = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            beat_tick = 1'b0;
            if (note_valid === 1'b1) saw_valid = 1'b1;
        end
        check("loop_end_no_valid", saw_valid, 0);
        check("loop_end_done_low", done, 0);
        check("loop_end_playing", playing, 1);
        check("loop_end_addr", mem_addr, 0);
        play_note(0, 3);
`else
        // Full song at one note per beat.
        do_reset();
        do_start();
        check("start_playing", playing, 1);
        for (int k = 0; k < 64; k++) play_note(k, 3);
        check("song_done", done, 1);
        check("song_playing_low", playing, 0);

        // End marker at slot 5 stops the song after note 4.
        ram[5] = NOTE_END_WORD;
        do_reset();
        do_start();
        for (int k = 0; k < 5; k++) play_note(k, 3);
        beat_tick = 1'b1;
        lat = 0;
        saw_valid = 1'b0;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            beat_tick = 1'b0;
            lat++;
            if (note_valid === 1'b1) saw_valid = 1'b1;
        end
        check("end_word_done_latency", lat, 3);
        check("end_word_no_valid", saw_valid, 0);
        check("end_word_last_idx", note_idx, 4);
        ram[5] = DATA_W'(6);

        // Back-pressure: first extra beat pends, second one overruns.
        ram[0] = make_note(4'h3, 4'h2, 24'h00ABCD);
        ram[1] = make_note(4'hA, 4'h1, 24'h123456);
        do_reset();
        note_ready = 1'b0;
        do_start();
        expect_note(0);
        beat_tick = 1'b1;
        wait_valid(8, lat);
        check("stall_latency", lat, 3);
        cyc(2);
        pulse_tick();
        cyc(1);
        check("stall_pending_no_overrun", overrun, 0);
        check("stall_valid_held", note_valid, 1);
        pulse_tick();
        cyc(1);
        check("stall_overrun", overrun, 1);
        check("stall_data_stable", note_data, 32'h320_0ABCD);
        check("stall_idx_stable", note_idx, 0);
        expect_note(1);
        note_ready = 1'b1;
        cyc(1);
        check("handshake_valid_drop", note_valid, 0);
        lat = 1;
        while (note_valid !== 1'b1 && lat < 8) begin
            cyc(1);
            lat++;
        end
        check("pending_restart_latency", lat, 4);
        check("overrun_sticky", overrun, 1);

        // Pause holds a beat until released.
        cyc(3);
        pause = 1'b1;
        pulse_tick();
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (note_valid === 1'b1) saw_valid = 1'b1;
        end
        check("pause_no_fetch", saw_valid, 0);
        check("pause_addr", mem_addr, 2);
        expect_note(2);
        pause = 1'b0;
        wait_valid(8, lat);
        check("unpause_latency", lat, 3);
        cyc(3);

        // Reset while presenting note 20.
        ram[0] = DATA_W'(1);
        ram[1] = DATA_W'(2);
        do_reset();
        do_start();
        for (int k = 0; k < 20; k++) play_note(k, 3);
        note_ready = 1'b0;
        beat_tick = 1'b1;
        wait_valid(8, lat);
        check("present_idx20", note_idx, 20);
        cyc(2);
        resetn = 1'b0;
        cyc(1);
        check("midreset_valid", note_valid, 0);
        check("midreset_idx", note_idx, 0);
        check("midreset_data", note_data, 0);
        check("midreset_playing", playing, 0);
        check("midreset_addr", mem_addr, 0);
        check("midreset_done", done, 0);
        resetn = 1'b1;
        note_ready = 1'b1;
        do_start();
        play_note(0, 3);
`endif

        cyc(3);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
